scpu_execute_mc: RTL and testbench
==================================

SCPU_EXECUTE_MC -- requirements
Module: scpu_execute_mc

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter DW, default 9: datapath width in bits, legal range 4..32.
REQ-003 Port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit: operation request.
REQ-006 Port in_ready, output, 1 bit: block can accept an operation this cycle.
REQ-007 Port dc_op, input, 3 bits: opcode.
REQ-008 Port dc_rd, input, DW bits: destination operand, also the left operand.
REQ-009 Port dc_rs, input, DW bits: source operand, the right operand.
REQ-010 Port ex_valid, output, 1 bit: result available.
REQ-011 Port ex_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port ex_dout, output, DW bits: result.
REQ-013 Port ex_flags, output, 4 bits: result flags {N,V,C,Z}, with Z at bit 0.
REQ-014 Port busy, output, 1 bit: a multiply is in progress.

Function
REQ-015 Opcode map: 000 AND, 001 OR, 010 ADD, 011 SUB; these keep the existing 2-bit ALU encoding. 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-016 Handshakes: an operation is accepted when in_valid and in_ready are both high; a result is consumed when ex_valid and ex_ready are both high.
REQ-017 State machine states:
- IDLE
- MUL
- DONE
REQ-018 State transitions:
- IDLE, accept of a non-MUL op -> DONE.
- IDLE, accept of MUL -> MUL.
- MUL, after DW iterations -> DONE.
- DONE, consume with no new accept -> IDLE.
REQ-019 in_ready SHALL be (state==IDLE) or (state==DONE and ex_ready); it is combinational from state and ex_ready only.
REQ-020 Simultaneous consume and accept in DONE:
- Non-MUL op: the next cycle stays in DONE with the new result; ex_valid stays high.
- MUL: goes to MUL; ex_valid deasserts.
REQ-021 Latency from accept to ex_valid: non-MUL ops 1 cycle; MUL DW+1 cycles.
REQ-022 Operands and opcode SHALL be registered at accept; later input changes have no effect.
REQ-023 ex_valid SHALL be high exactly in DONE.
REQ-024 While ex_valid is high and ex_ready is low, ex_dout and ex_flags SHALL hold stable.
REQ-025 ADD: result = (rd+rs) mod 2^DW; C = carry out of bit DW-1.
REQ-026 SUB: result = (rd-rs) mod 2^DW; C = 1 when rd < rs unsigned (borrow).
REQ-027 V = two's-complement signed overflow for ADD and SUB; V = 0 for all other ops.
REQ-028 Shifts:
- SHL: rd shifted left by 1; C = old rd[DW-1].
- SHR: logical right shift by 1; C = old rd[0].
REQ-029 AND, OR, XOR: C = 0.
REQ-030 MUL: unsigned shift-add, one partial product per cycle, DW cycles; result = low DW bits; C = 1 when any upper product bit is nonzero.
REQ-031 Z = (result == 0); N = result[DW-1]; both apply to all ops.
REQ-032 busy SHALL be high exactly in state MUL.

Reset
REQ-033 Asserting rst_n low SHALL immediately force the following; this also applies mid-multiply, which is aborted and discarded:
- state to IDLE
- ex_valid, ex_dout, ex_flags, busy all to 0
- iteration counter and partial product to 0
REQ-034 in_ready SHALL be 1 during reset and in the first cycle after rst_n releases.

Structure
REQ-035 Package scpu_alu_pkg SHALL hold:
- opcode constants
- flag bit indices (FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3)
- state encoding
REQ-036 The sequential multiplier SHALL be sub-module scpu_mul_seq, parametrised by DW. Ports: clk, rst_n, start, a, b, done, prod (2*DW bits).
REQ-037 The FSM, the single-cycle ALU and the flag logic SHALL reside in scpu_execute_mc.

Verification (DW=9)
REQ-038 ADD rd=9'h1FF, rs=9'h001 -> after 1 cycle: ex_valid=1, ex_dout=0, Z=1, C=1, V=0, N=0.
REQ-039 SUB rd=5, rs=7 -> ex_dout=9'h1FE, C=1, N=1, Z=0, V=0.
REQ-040 MUL cases:
- rd=20, rs=13: busy for 9 cycles, then ex_valid on cycle 10 with ex_dout=9'h104, C=0.
- rd=32, rs=32: ex_dout=0, Z=1, C=1.
REQ-041 Hold ex_ready low for 3 cycles after an ADD result -> ex_dout and ex_flags stable and in_ready=0; raise ex_ready with a new op pending -> new op accepted that same cycle.
REQ-042 Back-to-back non-MUL ops with in_valid and ex_ready held high -> one result per cycle and ex_valid continuously high.
REQ-043 Drop rst_n 4 cycles into a MUL -> all outputs 0 at once; after release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/scpu_alu_pkg.sv
// scpu_alu_pkg
// Shared definitions for the multi-cycle execute stage: opcode constants,
// flag bit positions inside the {N,V,C,Z} flag vector, FSM state encoding
// and a small helper that packs individual flag bits into that vector.
package scpu_alu_pkg;

  // The low four opcodes match the original 2-bit ALU encoding
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic v,
                                            input logic c, input logic z);
    logic [3:0] f;
    f        = 4'b0000;
    f[FLG_N] = n;
    f[FLG_V] = v;
    f[FLG_C] = c;
    f[FLG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/scpu_mul_seq.sv
// scpu_mul_seq
// Unsigned shift-add multiplier, one partial product per clock.
// The first partial product is folded in on the start edge, so after DW
// edges (start edge included) the product is complete and done is high.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin a new multiply (1-cycle pulse)
//   a, b       : multiplicand, multiplier (DW bits, captured on start)
//   done       : product valid (combinational from internal registers)
//   prod       : full 2*DW-bit product
module scpu_mul_seq #(
  parameter int DW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic [2*DW-1:0] prod
);

  localparam int CW = $clog2(DW + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic            done_s;

  assign done_s = run_q && (cnt_q == CW'(DW));
  assign done   = done_s;
  assign prod   = acc_q;

  // Iteration datapath: multiplicand shifts left, multiplier shifts right
  always_comb begin
    cnt_d    = cnt_q;
    run_d    = run_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      acc_d    = b[0] ? {{DW{1'b0}}, a} : {(2*DW){1'b0}};
      mcand_d  = {{(DW-1){1'b0}}, a, 1'b0};
      mplier_d = {1'b0, b[DW-1:1]};
      cnt_d    = CW'(1);
      run_d    = 1'b1;
    end else if (run_q && !done_s) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*DW){1'b0}});
      mcand_d  = {mcand_q[2*DW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[DW-1:1]};
      cnt_d    = cnt_q + CW'(1);
    end else if (done_s) begin
      run_d    = 1'b0;
    end else begin
      run_d    = run_q;
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CW{1'b0}};
      run_q    <= 1'b0;
      mcand_q  <= {(2*DW){1'b0}};
      mplier_q <= {DW{1'b0}};
      acc_q    <= {(2*DW){1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/scpu_execute_mc.sv
// scpu_execute_mc
// Multi-cycle execute stage: single-cycle ALU ops (AND/OR/ADD/SUB/XOR/
// SHL/SHR) complete one cycle after accept, MUL runs on scpu_mul_seq for
// DW cycles. Result and flags are registered and held while ex_valid is
// high and the consumer stalls.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation request handshake
//   dc_op, dc_rd, dc_rs : opcode, left operand, right operand
//   ex_valid / ex_ready : result handshake
//   ex_dout, ex_flags   : result and {N,V,C,Z} flags
//   busy                : multiply in progress
module scpu_execute_mc
  import scpu_alu_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    dc_op,
  input  logic [DW-1:0] dc_rd,
  input  logic [DW-1:0] dc_rs,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] ex_dout,
  output logic [3:0]    ex_flags,
  output logic          busy
);

  state_e          state_q, state_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [3:0]      flags_q, flags_d;
  logic            in_ready_s;
  logic            accept_s;
  logic            mul_start_s;
  logic            mul_done_s;
  logic [2*DW-1:0] mul_prod_s;
  logic [DW-1:0]   alu_res_s;
  logic [3:0]      alu_flags_s;
  logic [DW:0]     add_s;
  logic [DW:0]     sub_s;
  logic [DW-1:0]   mul_res_s;
  logic [3:0]      mul_flags_s;

  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && ex_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign in_ready   = in_ready_s;
  assign ex_valid   = (state_q == ST_DONE);
  assign busy       = (state_q == ST_MUL);
  assign ex_dout    = dout_q;
  assign ex_flags   = flags_q;

  // Extra top bit carries ADD carry-out / SUB borrow
  assign add_s = {1'b0, dc_rd} + {1'b0, dc_rs};
  assign sub_s = {1'b0, dc_rd} - {1'b0, dc_rs};

  scpu_mul_seq #(.DW(DW)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start_s),
    .a     (dc_rd),
    .b     (dc_rs),
    .done  (mul_done_s),
    .prod  (mul_prod_s)
  );

  assign mul_res_s   = mul_prod_s[DW-1:0];
  assign mul_flags_s = pack_flags(mul_res_s[DW-1], 1'b0,
                                  |mul_prod_s[2*DW-1:DW],
                                  (mul_res_s == {DW{1'b0}}));

  // Single-cycle ALU with flag generation
  always_comb begin
    logic c_v;
    logic v_v;
    alu_res_s = {DW{1'b0}};
    c_v       = 1'b0;
    v_v       = 1'b0;
    case (dc_op)
      OP_AND: alu_res_s = dc_rd & dc_rs;
      OP_OR:  alu_res_s = dc_rd | dc_rs;
      OP_XOR: alu_res_s = dc_rd ^ dc_rs;
      OP_ADD: begin
        alu_res_s = add_s[DW-1:0];
        c_v       = add_s[DW];
        // Same-sign operands producing a different-sign result
        v_v       = (dc_rd[DW-1] == dc_rs[DW-1]) && (add_s[DW-1] != dc_rd[DW-1]);
      end
      OP_SUB: begin
        alu_res_s = sub_s[DW-1:0];
        c_v       = sub_s[DW];
        // Opposite-sign operands where the result sign departs from rd
        v_v       = (dc_rd[DW-1] != dc_rs[DW-1]) && (sub_s[DW-1] != dc_rd[DW-1]);
      end
      OP_SHL: begin
        alu_res_s = {dc_rd[DW-2:0], 1'b0};
        c_v       = dc_rd[DW-1];
      end
      OP_SHR: begin
        alu_res_s = {1'b0, dc_rd[DW-1:1]};
        c_v       = dc_rd[0];
      end
      default: begin
        alu_res_s = {DW{1'b0}};
        c_v       = 1'b0;
      end
    endcase
    alu_flags_s = pack_flags(alu_res_s[DW-1], v_v, c_v, (alu_res_s == {DW{1'b0}}));
  end

  // Next-state and result-load logic
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    flags_d     = flags_q;
    mul_start_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (dc_op == OP_MUL) begin
            state_d     = ST_MUL;
            mul_start_s = 1'b1;
          end else begin
            state_d = ST_DONE;
            dout_d  = alu_res_s;
            flags_d = alu_flags_s;
          end
        end else if ((state_q == ST_DONE) && ex_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          state_d = ST_DONE;
          dout_d  = mul_res_s;
          flags_d = mul_flags_s;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dout_q  <= {DW{1'b0}};
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_scpu_execute_mc.sv
module tb_scpu_execute_mc;

  localparam int DW   = 9;
  localparam int FULL = 1 << DW;
  localparam int HALF = 1 << (DW - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          ex_ready = 1'b0;
  logic [2:0]    dc_op = 3'b000;
  logic [DW-1:0] dc_rd = '0;
  logic [DW-1:0] dc_rs = '0;
  logic          in_ready;
  logic          ex_valid;
  logic          busy;
  logic [DW-1:0] ex_dout;
  logic [3:0]    ex_flags;

  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag  = "init";

  scpu_execute_mc #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dc_op    (dc_op),
    .dc_rd    (dc_rd),
    .dc_rs    (dc_rs),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_dout  (ex_dout),
    .ex_flags (ex_flags),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%s]: got %0h required %0h", name, cur_tag, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions
  function automatic void model(input int op, input int rd, input int rs,
                                output logic [DW-1:0] dout, output logic [3:0] fl);
    int r, srd, srs, sr;
    logic c, v, z, n;
    srd = (rd >= HALF) ? rd - FULL : rd;
    srs = (rs >= HALF) ? rs - FULL : rs;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      0: r = rd & rs;
      1: r = rd | rs;
      2: begin r = rd + rs; c = (r >= FULL); sr = srd + srs; v = (sr >= HALF) || (sr < -HALF); end
      3: begin r = rd - rs; c = (rd < rs);   sr = srd - srs; v = (sr >= HALF) || (sr < -HALF); end
      4: r = rd ^ rs;
      5: begin r = rd * 2; c = (rd >= HALF); end
      6: begin r = rd / 2; c = (rd % 2) == 1; end
      default: begin r = rd * rs; c = (r >= FULL); end
    endcase
    r = r & (FULL - 1);
    dout = r[DW-1:0];
    z = (r == 0);
    n = (r >= HALF);
    fl = {n, v, c, z};
  endfunction

  // Issue one op from IDLE, wait for result, hold it `hold` cycles, consume
  task automatic do_op(input logic [2:0] op, input logic [DW-1:0] rd, input logic [DW-1:0] rs,
                       input logic [DW-1:0] e_dout, input logic [3:0] e_fl, input int hold);
    int lat;
    int exp_lat;
    exp_lat = (op == 3'b111) ? DW + 1 : 1;
    chk("ready_before", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; dc_op = op; dc_rd = rd; dc_rs = rs; ex_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dc_op = 3'($urandom_range(0, 7)); dc_rd = DW'($urandom); dc_rs = DW'($urandom);
    lat = 1;
    while (!ex_valid && lat < 4 * DW) begin
      chk("busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("dout", {23'b0, ex_dout}, {23'b0, e_dout});
    chk("flags", {28'b0, ex_flags}, {28'b0, e_fl});
    chk("busy_done", {31'b0, busy}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, ex_valid}, 32'd1);
      chk("hold_dout", {23'b0, ex_dout}, {23'b0, e_dout});
      chk("hold_flags", {28'b0, ex_flags}, {28'b0, e_fl});
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
    end
    ex_ready = 1'b1;
    @(posedge clk); #1;
    ex_ready = 1'b0;
    chk("consumed", {31'b0, ex_valid}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] rd;
    logic [DW-1:0] rs;
    logic [DW-1:0] dout;
    logic [3:0]    flags;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [DW-1:0] e_d;
    logic [3:0]    e_f;
    logic [DW-1:0] q_d[$];
    logic [3:0]    q_f[$];
    int            stale;
    int            lat;

    vecs[0]  = '{3'b010, 9'h1FF, 9'h001, 9'h000, 4'b0011};
    vecs[1]  = '{3'b011, 9'd5,   9'd7,   9'h1FE, 4'b1010};
    vecs[2]  = '{3'b111, 9'd20,  9'd13,  9'h104, 4'b1000};
    vecs[3]  = '{3'b111, 9'd32,  9'd32,  9'h000, 4'b0011};
    vecs[4]  = '{3'b000, 9'h0F0, 9'h0FF, 9'h0F0, 4'b0000};
    vecs[5]  = '{3'b001, 9'h100, 9'h001, 9'h101, 4'b1000};
    vecs[6]  = '{3'b100, 9'h155, 9'h155, 9'h000, 4'b0001};
    vecs[7]  = '{3'b101, 9'h180, 9'h000, 9'h100, 4'b1010};
    vecs[8]  = '{3'b110, 9'h003, 9'h000, 9'h001, 4'b0010};
    vecs[9]  = '{3'b010, 9'h0FF, 9'h001, 9'h100, 4'b1100};
    vecs[10] = '{3'b011, 9'h100, 9'h001, 9'h0FF, 4'b0100};
    vecs[11] = '{3'b111, 9'h1FF, 9'h1FF, 9'h001, 4'b0010};

    // Reset state
    #2;
    cur_tag = "reset";
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dout", {23'b0, ex_dout}, 32'd0);
    chk("rst_flags", {28'b0, ex_flags}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      do_op(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].dout, vecs[i].flags, i % 2);
    end

    // Stall then accept a pending op in the same cycle ex_ready rises
    cur_tag = "stall";
    in_valid = 1'b1; dc_op = 3'b010; dc_rd = 9'h010; dc_rs = 9'h020; ex_ready = 1'b0;
    @(posedge clk); #1;
    dc_op = 3'b001; dc_rd = 9'h0A0; dc_rs = 9'h005;
    chk("stall_valid", {31'b0, ex_valid}, 32'd1);
    for (int h = 0; h < 3; h++) begin
      @(posedge clk); #1;
      chk("stall_dout", {23'b0, ex_dout}, 32'h030);
      chk("stall_flags", {28'b0, ex_flags}, 32'd0);
      chk("stall_ready", {31'b0, in_ready}, 32'd0);
    end
    ex_ready = 1'b1;
    #1;
    chk("stall_accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_new_valid", {31'b0, ex_valid}, 32'd1);
    chk("stall_new_dout", {23'b0, ex_dout}, 32'h0A5);
    @(posedge clk); #1;
    ex_ready = 1'b0;
    chk("stall_idle", {31'b0, ex_valid}, 32'd0);

    // Back-to-back single-cycle ops, then a MUL accepted from DONE
    cur_tag = "b2b";
    ex_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dc_op = 3'($urandom_range(0, 6)); dc_rd = DW'($urandom); dc_rs = DW'($urandom);
      model(int'(dc_op), int'(dc_rd), int'(dc_rs), e_d, e_f);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_valid", {31'b0, ex_valid}, 32'd1);
      chk("b2b_dout", {23'b0, ex_dout}, {23'b0, e_d});
      chk("b2b_flags", {28'b0, ex_flags}, {28'b0, e_f});
    end
    dc_op = 3'b111; dc_rd = 9'd20; dc_rs = 9'd13;
    #1;
    chk("b2b_mul_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; ex_ready = 1'b0; dc_rd = 9'd0;
    chk("b2b_mul_valid", {31'b0, ex_valid}, 32'd0);
    chk("b2b_mul_busy", {31'b0, busy}, 32'd1);
    lat = 1;
    while (!ex_valid && lat < 4 * DW) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_mul_lat", lat, DW + 1);
    chk("b2b_mul_dout", {23'b0, ex_dout}, 32'h104);
    ex_ready = 1'b1;
    @(posedge clk); #1;
    ex_ready = 1'b0;

    // Reset dropped four cycles into a multiply
    cur_tag = "mul_reset";
    in_valid = 1'b1; dc_op = 3'b111; dc_rd = 9'd31; dc_rs = 9'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mr_busy", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, ex_valid}, 32'd0);
    chk("mr_busy0", {31'b0, busy}, 32'd0);
    chk("mr_dout", {23'b0, ex_dout}, 32'd0);
    chk("mr_flags", {28'b0, ex_flags}, 32'd0);
    chk("mr_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_ready_rel", {31'b0, in_ready}, 32'd1);
    stale = 0;
    repeat (DW + 3) begin
      @(posedge clk); #1;
      if (ex_valid || busy) stale++;
    end
    chk("mr_no_stale", stale, 32'd0);
    do_op(3'b010, 9'd3, 9'd4, 9'd7, 4'b0000, 0);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [2:0]    op;
      logic [DW-1:0] a, b;
      cur_tag = $sformatf("rand%0d", i);
      op = 3'($urandom_range(0, 7)); a = DW'($urandom); b = DW'($urandom);
      model(int'(op), int'(a), int'(b), e_d, e_f);
      q_d.push_back(e_d); q_f.push_back(e_f);
      do_op(op, a, b, q_d.pop_front(), q_f.pop_front(), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
